multicycle_control_fsm: RTL

- Multicycle successor to the single-cycle TSC control decoder.
- Sequences each instruction through IF/ID/EX/MEM/WB states and waits on variable-latency instruction and data memories via ready handshakes.
- Adds a HALT state, a retire strobe, and retired-instruction and stall-cycle counters.
- Sits between the instruction-type decoder and the datapath; `alu_control` consumes its `alu_mode` output.

---
 rtl/multicycle_control_fsm_pkg.sv | 59 +++++
 rtl/mcf_counters.sv | 26 ++
 rtl/multicycle_control_fsm.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle control FSM: state codes, decoder
// instruction types, datapath mux selects and the opcodes the FSM inspects.
package multicycle_control_fsm_pkg;

  typedef enum logic [2:0] {
    STATE_IF   = 3'd0,
    STATE_ID   = 3'd1,
    STATE_EX   = 3'd2,
    STATE_MEM  = 3'd3,
    STATE_WB   = 3'd4,
    STATE_HALT = 3'd5
  } state_e;

  localparam logic [2:0] INSTTYPE_RTYPE  = 3'd0;
  localparam logic [2:0] INSTTYPE_IMM    = 3'd1;  // ADI, ORI
  localparam logic [2:0] INSTTYPE_MEM    = 3'd2;  // LHI, LWD, SWD
  localparam logic [2:0] INSTTYPE_BRANCH = 3'd3;
  localparam logic [2:0] INSTTYPE_JUMP   = 3'd4;
  localparam logic [2:0] INSTTYPE_OUTPUT = 3'd5;
  localparam logic [2:0] INSTTYPE_HALT   = 3'd6;
  localparam logic [2:0] INSTTYPE_NOP    = 3'd7;

  localparam logic [1:0] PCSRC_SEQ    = 2'd0;
  localparam logic [1:0] PCSRC_JUMP   = 2'd1;
  localparam logic [1:0] PCSRC_BRANCH = 2'd2;
  localparam logic [1:0] PCSRC_REG    = 2'd3;

  localparam logic       ALUSRCA_REG  = 1'b0;
  localparam logic [1:0] ALUSRCB_REG  = 2'd0;
  localparam logic [1:0] ALUSRCB_IMM  = 2'd1;
  localparam logic [1:0] ALUSRCB_ZERO = 2'd2;

  localparam logic [1:0] REGWRITESRC_IMM = 2'd0;
  localparam logic [1:0] REGWRITESRC_ALU = 2'd1;
  localparam logic [1:0] REGWRITESRC_MEM = 2'd2;
  localparam logic [1:0] REGWRITESRC_PC  = 2'd3;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_R2 = 2'd2;

  localparam logic [3:0] OPCODE_BGZ   = 4'd2;
  localparam logic [3:0] OPCODE_BLZ   = 4'd3;
  localparam logic [3:0] OPCODE_LHI   = 4'd6;
  localparam logic [3:0] OPCODE_LWD   = 4'd7;
  localparam logic [3:0] OPCODE_SWD   = 4'd8;
  localparam logic [3:0] OPCODE_JMP   = 4'd9;
  localparam logic [3:0] OPCODE_JAL   = 4'd10;
  localparam logic [3:0] OPCODE_RTYPE = 4'd15;

  localparam logic [5:0] FUNC_TCP = 6'd5;
  localparam logic [5:0] FUNC_JRL = 6'd26;

  // Linking jumps (JAL, JRL) need a WB cycle to store the return address in $2.
  function automatic logic is_link(input logic [3:0] op, input logic [5:0] fn);
    return (op == OPCODE_JAL) || (op == OPCODE_RTYPE && fn == FUNC_JRL);
  endfunction

endpackage

// File: rtl/mcf_counters.sv
// Retired-instruction and memory-stall counters; both wrap modulo 2^W.
module mcf_counters #(
  parameter int INST_CNT_W  = 16,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   retire,
  input  logic                   stall,
  output logic [INST_CNT_W-1:0]  num_inst,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_inst     <= '0;
      stall_cycles <= '0;
    end else begin
      if (retire) num_inst <= num_inst + INST_CNT_W'(1);
      if (stall)  stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle TSC controller: IF/ID/EX/MEM/WB sequencing with ready
// handshakes on both memories, an absorbing HALT and retire/stall counters.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int INST_CNT_W  = 16,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             opcode,
  input  logic [5:0]             func_code,
  input  logic [2:0]             inst_type,
  input  logic                   i_mem_ready,
  input  logic                   d_mem_ready,
  output logic [2:0]             state,
  output logic                   pc_write,
  output logic                   pc_write_cond,
  output logic [1:0]             pc_src,
  output logic                   i_or_d,
  output logic                   i_mem_read,
  output logic                   d_mem_read,
  output logic                   d_mem_write,
  output logic                   ir_write,
  output logic                   alu_mode,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic                   alu_src_swap,
  output logic                   reg_write,
  output logic [1:0]             reg_write_src,
  output logic [1:0]             reg_dst,
  output logic                   output_write,
  output logic                   retire,
  output logic                   is_halted,
  output logic [INST_CNT_W-1:0]  num_inst,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  state_e cur_state, next_state;
  logic   stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur_state <= STATE_IF;
    else       cur_state <= next_state;
  end

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      STATE_IF:  if (i_mem_ready) next_state = STATE_ID;
      STATE_ID: begin
        case (inst_type)
          INSTTYPE_HALT:                 next_state = STATE_HALT;
          INSTTYPE_NOP, INSTTYPE_OUTPUT: next_state = STATE_IF;
          INSTTYPE_JUMP:
            next_state = is_link(opcode, func_code) ? STATE_WB : STATE_IF;
          default:                       next_state = STATE_EX;
        endcase
      end
      STATE_EX: begin
        case (inst_type)
          INSTTYPE_BRANCH: next_state = STATE_IF;
          INSTTYPE_MEM:
            next_state = (opcode == OPCODE_LHI) ? STATE_WB : STATE_MEM;
          default:         next_state = STATE_WB;
        endcase
      end
      STATE_MEM:
        if (d_mem_ready) next_state = (opcode == OPCODE_LWD) ? STATE_WB : STATE_IF;
      STATE_WB:   next_state = STATE_IF;
      STATE_HALT: next_state = STATE_HALT;
      default:    next_state = STATE_IF;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PCSRC_SEQ;
    i_or_d        = 1'b0;
    i_mem_read    = 1'b0;
    d_mem_read    = 1'b0;
    d_mem_write   = 1'b0;
    ir_write      = 1'b0;
    alu_mode      = 1'b0;
    alu_src_a     = ALUSRCA_REG;
    alu_src_b     = ALUSRCB_REG;
    alu_src_swap  = 1'b0;
    reg_write     = 1'b0;
    reg_write_src = REGWRITESRC_IMM;
    reg_dst       = REGDST_RT;
    output_write  = 1'b0;
    retire        = 1'b0;
    is_halted     = 1'b0;
    stall         = 1'b0;
    // Reset parks the FSM in IF, whose request would otherwise be visible.
    if (!reset) begin
      case (cur_state)
        STATE_IF: begin
          i_mem_read = 1'b1;
          if (i_mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end else begin
            stall = 1'b1;
          end
        end
        STATE_ID: begin
          case (inst_type)
            INSTTYPE_HALT, INSTTYPE_NOP: retire = 1'b1;
            INSTTYPE_OUTPUT: begin
              output_write = 1'b1;
              retire       = 1'b1;
            end
            INSTTYPE_JUMP: begin
              pc_write = 1'b1;
              pc_src   = (opcode == OPCODE_JMP || opcode == OPCODE_JAL) ? PCSRC_JUMP
                                                                        : PCSRC_REG;
              retire   = !is_link(opcode, func_code);
            end
            default: ;
          endcase
        end
        STATE_EX: begin
          case (inst_type)
            INSTTYPE_RTYPE: begin
              alu_mode = 1'b1;
              if (func_code == FUNC_TCP) begin
                alu_src_b    = ALUSRCB_ZERO;
                alu_src_swap = 1'b1;
              end
            end
            INSTTYPE_IMM: begin
              alu_mode  = 1'b1;
              alu_src_b = ALUSRCB_IMM;
            end
            INSTTYPE_BRANCH: begin
              alu_mode      = 1'b1;
              pc_src        = PCSRC_BRANCH;
              pc_write_cond = 1'b1;
              retire        = 1'b1;
              if (opcode == OPCODE_BGZ || opcode == OPCODE_BLZ) alu_src_b = ALUSRCB_ZERO;
              alu_src_swap  = (opcode == OPCODE_BLZ);
            end
            INSTTYPE_MEM: alu_src_b = ALUSRCB_IMM;
            default: ;
          endcase
        end
        STATE_MEM: begin
          i_or_d      = 1'b1;
          d_mem_read  = (opcode == OPCODE_LWD);
          d_mem_write = (opcode == OPCODE_SWD);
          if (d_mem_ready) retire = (opcode != OPCODE_LWD);
          else             stall  = 1'b1;
        end
        STATE_WB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
          case (inst_type)
            INSTTYPE_RTYPE: begin
              reg_write_src = REGWRITESRC_ALU;
              reg_dst       = REGDST_RD;
            end
            INSTTYPE_IMM: reg_write_src = REGWRITESRC_ALU;
            INSTTYPE_MEM:
              reg_write_src = (opcode == OPCODE_LHI) ? REGWRITESRC_IMM : REGWRITESRC_MEM;
            INSTTYPE_JUMP: begin
              reg_write_src = REGWRITESRC_PC;
              reg_dst       = REGDST_R2;
            end
            default: ;
          endcase
        end
        STATE_HALT: is_halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign state = cur_state;

  mcf_counters #(
    .INST_CNT_W (INST_CNT_W),
    .STALL_CNT_W(STALL_CNT_W)
  ) u_counters (
    .clk         (clk),
    .reset       (reset),
    .retire      (retire),
    .stall       (stall),
    .num_inst    (num_inst),
    .stall_cycles(stall_cycles)
  );

endmodule
